// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes and FSM states.
package md_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

endpackage

// File: rtl/div_core.sv
// Iterative restoring divider on unsigned magnitudes; one quotient bit per cycle.
// A start pulse loads the operands; done is high during the final iteration cycle.
module div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [WIDTH:0]   shifted;
  logic             take;
  logic [WIDTH-1:0] step_quo, step_rem;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    run_d = run_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;

    // Partial remainder stays below the divisor, so the restored value fits WIDTH bits.
    shifted  = {rem_q, quo_q[WIDTH-1]};
    take     = (shifted >= {1'b0, dvs_q});
    step_rem = take ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
    step_quo = {quo_q[WIDTH-2:0], take};

    if (!run_q) begin
      if (start) begin
        run_d = 1'b1;
        cnt_d = CW'(WIDTH);
        quo_d = dividend;
        rem_d = '0;
        dvs_d = divisor;
      end
    end else begin
      quo_d = step_quo;
      rem_d = step_rem;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset_n) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

  assign busy      = run_q;
  assign done      = run_q && (cnt_q == CW'(1));
  assign quotient  = step_quo;
  assign remainder = step_rem;

endmodule

// File: rtl/mult_div_unit.sv
// MIPS-style HI/LO multiply/divide unit: fixed-latency multiply, iterative divide,
// and direct HI/LO writes. Sign handling around the unsigned divider lives here.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               sgn_q, sgn_d;
  logic               done_q, done_d;

  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] a_ext, b_ext, product;
  logic               div_start, div_busy, div_done;
  logic [WIDTH-1:0]   div_quo, div_rem, quo_s, rem_s;

  div_core #(.WIDTH(WIDTH)) u_div_core (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (div_start),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Operand datapath works only from the registered copies.
  always_comb begin
    neg_a   = sgn_q & a_q[WIDTH-1];
    neg_b   = sgn_q & b_q[WIDTH-1];
    mag_a   = neg_a ? -a_q : a_q;
    mag_b   = neg_b ? -b_q : b_q;
    a_ext   = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    b_ext   = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    product = a_ext * b_ext;

    // Quotient truncates toward zero; remainder follows the dividend's sign.
    // Most-negative / -1 falls out naturally: magnitude 2^(W-1) negates to itself.
    if (b_q == '0) begin
      quo_s = neg_a ? WIDTH'(1) : '1;
      rem_s = a_q;
    end else begin
      quo_s = (neg_a ^ neg_b) ? -div_quo : div_quo;
      rem_s = neg_a ? -div_rem : div_rem;
    end

    div_start = (state_q == ST_DIV) && !div_busy;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              a_d     = a;
              b_d     = b;
              sgn_d   = (op == OP_MULT);
              cnt_d   = CNT_W'(MULT_CYCLES - 1);
              state_d = ST_MUL;
            end
            OP_DIV, OP_DIVU: begin
              a_d     = a;
              b_d     = b;
              sgn_d   = (op == OP_DIV);
              state_d = ST_DIV;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (cnt_q == '0) begin
          {hi_d, lo_d} = product;
          done_d       = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DIV: begin
        if (div_done) begin
          hi_d    = rem_s;
          lo_d    = quo_s;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed checks on a 32-bit unit plus a randomized sweep of a 16-bit,
// single-cycle-multiply unit against an arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  always #5 clk = ~clk;

  logic        s32_start;
  logic [2:0]  s32_op;
  logic [31:0] s32_a, s32_b, hi32, lo32;
  logic        busy32, done32;

  logic        s16_start;
  logic [2:0]  s16_op;
  logic [15:0] s16_a, s16_b, hi16, lo16;
  logic        busy16, done16;

  int total = 0;
  int bad   = 0;

  mult_div_unit #(.WIDTH(32), .MULT_CYCLES(5)) dut32 (
    .clk(clk), .reset_n(reset_n), .start(s32_start), .op(s32_op),
    .a(s32_a), .b(s32_b), .hi(hi32), .lo(lo32), .busy(busy32), .done(done32)
  );

  mult_div_unit #(.WIDTH(16), .MULT_CYCLES(1)) dut16 (
    .clk(clk), .reset_n(reset_n), .start(s16_start), .op(s16_op),
    .a(s16_a), .b(s16_b), .hi(hi16), .lo(lo16), .busy(busy16), .done(done16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain signed/unsigned arithmetic on 16-bit operands.
  task automatic model16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         inout logic [15:0] hi, inout logic [15:0] lo);
    shortint sa, sb;
    int      ua, ub, q, r;
    longint  p;
    sa = shortint'(a);
    sb = shortint'(b);
    ua = int'(a);
    ub = int'(b);
    case (op)
      3'd0: begin p = longint'(sa) * longint'(sb); hi = p[31:16]; lo = p[15:0]; end
      3'd1: begin p = longint'(ua) * longint'(ub); hi = p[31:16]; lo = p[15:0]; end
      3'd2: begin
        if (b == 16'h0) begin
          lo = (sa >= 0) ? 16'hFFFF : 16'h0001;
          hi = a;
        end else if (sa == -16'sd32768 && sb == -16'sd1) begin
          lo = 16'h8000;
          hi = 16'h0000;
        end else begin
          q = int'(sa) / int'(sb);
          r = int'(sa) % int'(sb);
          lo = q[15:0];
          hi = r[15:0];
        end
      end
      3'd3: begin
        if (b == 16'h0) begin
          lo = 16'hFFFF;
          hi = a;
        end else begin
          q = ua / ub;
          r = ua % ub;
          lo = q[15:0];
          hi = r[15:0];
        end
      end
      3'd4: hi = a;
      3'd5: lo = a;
      default: ;
    endcase
  endtask

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      3:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  // Issue one long operation on the 32-bit unit and check latency, hold and result.
  task automatic run32(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit poke, input int exp_cyc,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] old_hi, old_lo;
    int  n;
    bit  hold;
    old_hi = hi32;
    old_lo = lo32;
    s32_start = 1'b1; s32_op = op; s32_a = a; s32_b = b;
    step();
    s32_start = 1'b0; s32_a = ~a; s32_b = b ^ 32'h5A5A_A5A5;
    n = 0;
    hold = 1'b1;
    while (busy32 && n < 100) begin
      if (hi32 !== old_hi || lo32 !== old_lo || done32 !== 1'b0) hold = 1'b0;
      if (poke && n == 1) begin
        s32_start = 1'b1; s32_op = 3'd4; s32_a = 32'h1234_5678;
      end else begin
        s32_start = 1'b0;
      end
      step();
      n++;
    end
    s32_start = 1'b0;
    check({tag, " busy_cycles"}, 64'(n), 64'(exp_cyc));
    check({tag, " hold"}, 64'(hold), 64'd1);
    check({tag, " done"}, 64'(done32), 64'd1);
    check({tag, " hi"}, 64'(hi32), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo32), 64'(exp_lo));
    step();
    check({tag, " done_pulse_end"}, 64'(done32), 64'd0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [15:0] a, b, ref_hi, ref_lo;
    int          n;
    bit          quiet;

    reset_n = 1'b0;
    s32_start = 1'b0; s32_op = '0; s32_a = '0; s32_b = '0;
    s16_start = 1'b0; s16_op = '0; s16_a = '0; s16_b = '0;
    step();
    step();
    check("reset hi", 64'(hi32), 64'd0);
    check("reset lo", 64'(lo32), 64'd0);
    check("reset busy", 64'(busy32), 64'd0);
    check("reset done", 64'(done32), 64'd0);
    reset_n = 1'b1;
    step();

    run32("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run32("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run32("divu_zero", 3'd3, 32'd7, 32'd0, 1'b0, 33, 32'd7, 32'hFFFF_FFFF);
    run32("multu_poke", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5, 32'hFFFF_FFFE, 32'h1);
    run32("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 33, 32'h0, 32'h8000_0000);
    run32("div_zero_neg", 3'd2, 32'hFFFF_FFF0, 32'd0, 1'b0, 33, 32'hFFFF_FFF0, 32'h1);

    // Reserved op leaves everything untouched.
    s32_start = 1'b1; s32_op = 3'd6; s32_a = 32'hDEAD_BEEF;
    step();
    s32_start = 1'b0;
    check("reserved busy", 64'(busy32), 64'd0);
    check("reserved hi", 64'(hi32), 64'hFFFF_FFF0);
    check("reserved lo", 64'(lo32), 64'h1);

    s32_start = 1'b1; s32_op = 3'd4; s32_a = 32'h0000_AAAA;
    step();
    s32_start = 1'b0;
    check("mthi hi", 64'(hi32), 64'h0000_AAAA);
    check("mthi busy", 64'(busy32), 64'd0);
    step();
    check("mthi done", 64'(done32), 64'd0);

    // Reset in the tenth busy cycle of a divide aborts it.
    s32_start = 1'b1; s32_op = 3'd3; s32_a = 32'd100; s32_b = 32'd3;
    step();
    s32_start = 1'b0;
    repeat (9) step();
    check("abort busy_before", 64'(busy32), 64'd1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("abort hi", 64'(hi32), 64'd0);
    check("abort lo", 64'(lo32), 64'd0);
    check("abort busy", 64'(busy32), 64'd0);
    check("abort done", 64'(done32), 64'd0);
    quiet = 1'b1;
    repeat (40) begin
      if (done32 !== 1'b0 || busy32 !== 1'b0 || lo32 !== 32'd0) quiet = 1'b0;
      step();
    end
    check("abort no_result", 64'(quiet), 64'd1);
    s32_start = 1'b1; s32_op = 3'd5; s32_a = 32'd5;
    step();
    s32_start = 1'b0;
    check("mtlo lo", 64'(lo32), 64'd5);
    check("mtlo busy", 64'(busy32), 64'd0);
    step();
    check("mtlo busy_after", 64'(busy32), 64'd0);

    // Random sweep; each op is issued on the cycle right after the previous done.
    ref_hi = 16'h0;
    ref_lo = 16'h0;
    for (int i = 0; i < 300; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick16();
      b  = pick16();
      if (i == 0) begin op = 3'd2; a = 16'h8000; b = 16'hFFFF; end
      if (i == 1) begin op = 3'd2; a = 16'h8001; b = 16'h0000; end
      if (i == 2) begin op = 3'd0; a = 16'h8000; b = 16'h8000; end
      model16(op, a, b, ref_hi, ref_lo);
      s16_start = 1'b1; s16_op = op; s16_a = a; s16_b = b;
      step();
      s16_start = 1'b0; s16_a = 16'($urandom); s16_b = 16'($urandom);
      if (op > 3'd3) begin
        check($sformatf("sweep%0d op%0d busy", i, op), 64'(busy16), 64'd0);
        check($sformatf("sweep%0d op%0d done", i, op), 64'(done16), 64'd0);
      end else begin
        n = 0;
        while (busy16 && n < 40) begin
          step();
          n++;
        end
        check($sformatf("sweep%0d op%0d cycles", i, op), 64'(n), (op < 3'd2) ? 64'd1 : 64'd17);
        check($sformatf("sweep%0d op%0d done", i, op), 64'(done16), 64'd1);
      end
      check($sformatf("sweep%0d op%0d a=%h b=%h hi", i, op, a, b), 64'(hi16), 64'(ref_hi));
      check($sformatf("sweep%0d op%0d a=%h b=%h lo", i, op, a, b), 64'(lo16), 64'(ref_lo));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
